// File: rtl/rvsteel_sim_pkg.sv
// Shared constants for the rvsteel simulation memory model.
// FSM encodings, default tohost mailbox, LFSR seed and taps.
package rvsteel_sim_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [31:0] TOHOST_DEFAULT = 32'h0000_1000;

   // Taps 16,14,13,11 map to bits 15,13,12,10.
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef struct packed {
      logic        wr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic        ok;
      logic        tohost;
      logic        conflict;
   } req_t;

endpackage

// File: rtl/rvsteel_sim_memory_if.sv
// Request/response bus between rvsteel_core and the simulation memory.
// Master drives requests; slave returns data and completion pulses.
interface rvsteel_sim_memory_if;

   logic [31:0] rw_address;
   logic [31:0] read_data;
   logic        read_request;
   logic        read_response;
   logic [31:0] write_data;
   logic [3:0]  write_strobe;
   logic        write_request;
   logic        write_response;

   modport master (
      output rw_address, read_request, write_data,
      output write_strobe, write_request,
      input  read_data, read_response, write_response
   );

   modport slave (
      input  rw_address, read_request, write_data,
      input  write_strobe, write_request,
      output read_data, read_response, write_response
   );

endinterface

// File: rtl/rvsteel_sim_lfsr.sv
// 16-bit Fibonacci LFSR used for random extra wait cycles.
// Only instantiated when RVSTEEL_SIM_RANDOM_WAIT_EN is defined.
module rvsteel_sim_lfsr
   import rvsteel_sim_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   output logic [15:0] value
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         value <= LFSR_SEED;
      else if (enable)
         value <= {value[14:0], ^(value & LFSR_TAPS)};
   end

endmodule

// File: rtl/rvsteel_sim_memory.sv
// Simulation memory with configurable latency, range check and tohost.
// Define RVSTEEL_SIM_RANDOM_WAIT_EN to add LFSR-driven extra wait cycles.
module rvsteel_sim_memory
  import rvsteel_sim_pkg::*;
#(
  parameter int unsigned MEMORY_SIZE    = 2097152,
  parameter logic [31:0] BOOT_ADDRESS   = 32'h0000_0000,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned WRITE_LATENCY  = 1,
  parameter logic [31:0] TOHOST_ADDRESS = TOHOST_DEFAULT,
  parameter              MEMORY_INIT_FILE = "",
  parameter int unsigned MAX_EXTRA_WAIT = 7
)(
  input  logic                 clock,
  input  logic                 reset,
  rvsteel_sim_memory_if.slave  bus,
  output logic                 test_done,
  output logic [31:0]          test_code,
  output logic                 bus_error
);

  localparam int unsigned WORDS = MEMORY_SIZE / 4;
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  if (READ_LATENCY < 1 || WRITE_LATENCY < 1 ||
      MEMORY_SIZE % 4 != 0 || MAX_EXTRA_WAIT > 4096) begin : g_bad_cfg
    $error("rvsteel_sim_memory: bad configuration");
  end

  logic [31:0] mem [WORDS];

  logic [1:0]    state;
  logic [15:0]   cnt;
  logic [15:0]   load;
  logic [15:0]   extra;
  req_t          req;
  req_t          nxt_req;
  logic [AW-1:0] idx;
  logic [AW-1:0] nxt_idx;
  logic [31:0]   offset;
  logic          accept;
  logic          go_resp;

`ifdef RVSTEEL_SIM_RANDOM_WAIT_EN
  logic [15:0] lfsr;

  rvsteel_sim_lfsr u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .enable (1'b1),
    .value  (lfsr)
  );

  assign extra = lfsr % 16'(MAX_EXTRA_WAIT + 1);
`else
  assign extra = '0;
`endif

  assign offset = bus.rw_address - BOOT_ADDRESS;
  assign accept = (state == ST_IDLE || state == ST_RESP) &&
                  (bus.read_request || bus.write_request);

  always_comb begin
    nxt_req = req;
    nxt_idx = idx;
    if (accept) begin
      nxt_req.wr       = bus.write_request;
      nxt_req.data     = bus.write_data;
      nxt_req.strb     = bus.write_strobe;
      nxt_req.ok       = offset < 32'(MEMORY_SIZE);
      nxt_req.tohost   = bus.write_request &&
                         bus.rw_address[31:2] == TOHOST_ADDRESS[31:2];
      nxt_req.conflict = bus.read_request && bus.write_request;
      nxt_idx          = offset[AW+1:2];
    end
  end

  assign load = (bus.write_request ? 16'(WRITE_LATENCY - 1)
                                   : 16'(READ_LATENCY - 1)) + extra;

  assign go_resp = (accept && load == '0) ||
                   (state == ST_WAIT && cnt == 16'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      req   <= '0;
      idx   <= '0;
    end else begin
      req <= nxt_req;
      idx <= nxt_idx;
      if (go_resp) begin
        state <= ST_RESP;
      end else if (accept) begin
        state <= ST_WAIT;
        cnt   <= load;
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 16'd1;
      end else begin
        state <= ST_IDLE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.read_response  <= 1'b0;
      bus.write_response <= 1'b0;
      bus.read_data      <= '0;
      test_done          <= 1'b0;
      test_code          <= '0;
      bus_error          <= 1'b0;
    end else begin
      bus.read_response  <= go_resp && !nxt_req.wr;
      bus.write_response <= go_resp && nxt_req.wr;
      bus.read_data      <= (go_resp && !nxt_req.wr && nxt_req.ok) ?
                            mem[nxt_idx] : '0;
      if (go_resp && (!nxt_req.ok || nxt_req.conflict))
        bus_error <= 1'b1;
      if (go_resp && nxt_req.tohost) begin
        test_done <= 1'b1;
        test_code <= nxt_req.data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset && go_resp && nxt_req.wr && nxt_req.ok) begin
      for (int i = 0; i < 4; i++) begin
        if (nxt_req.strb[i])
          mem[nxt_idx][8*i +: 8] <= nxt_req.data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_rvsteel_sim_memory.sv
// Directed bench: three memories with read latency 1, 4 and 3.
// Checks latency, strobes, range errors, tohost, conflicts and reset.
module tb_rvsteel_sim_memory;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  strb = '0;
   logic [2:0]  rreq = '0;
   logic [2:0]  wreq = '0;
   logic [2:0]  rresp;
   logic [2:0]  wresp;
   logic [2:0]  tdone;
   logic [2:0]  berr;
   logic [31:0] rdata [3];
   logic [31:0] tcode [3];

   int ncmp = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   rvsteel_sim_memory_if bus [3] ();

   for (genvar g = 0; g < 3; g++) begin : g_bus
      assign bus[g].rw_address    = addr;
      assign bus[g].write_data    = wdata;
      assign bus[g].write_strobe  = strb;
      assign bus[g].read_request  = rreq[g];
      assign bus[g].write_request = wreq[g];
      assign rresp[g] = bus[g].read_response;
      assign wresp[g] = bus[g].write_response;
      assign rdata[g] = bus[g].read_data;
   end

   rvsteel_sim_memory #(.MEMORY_SIZE(8192), .READ_LATENCY(1)) u_a (
      .clock(clk), .reset(rst_n), .bus(bus[0]),
      .test_done(tdone[0]), .test_code(tcode[0]), .bus_error(berr[0])
   );

   rvsteel_sim_memory #(.MEMORY_SIZE(8192), .READ_LATENCY(4)) u_b (
      .clock(clk), .reset(rst_n), .bus(bus[1]),
      .test_done(tdone[1]), .test_code(tcode[1]), .bus_error(berr[1])
   );

   rvsteel_sim_memory #(.MEMORY_SIZE(8192), .READ_LATENCY(3)) u_c (
      .clock(clk), .reset(rst_n), .bus(bus[2]),
      .test_done(tdone[2]), .test_code(tcode[2]), .bus_error(berr[2])
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One request, then watch an 8-cycle window for responses.
   task automatic xact(
      input  int          k,
      input  bit          w,
      input  bit          r,
      input  logic [31:0] a,
      input  logic [31:0] d,
      input  logic [3:0]  s,
      output int          fr,
      output int          fw,
      output int          nr,
      output int          nw,
      output logic [31:0] rd,
      output logic [31:0] tc,
      output logic        td
   );
      @(posedge clk); #1;
      addr = a; wdata = d; strb = s;
      rreq[k] = r; wreq[k] = w;
      @(posedge clk); #1;
      rreq[k] = 1'b0; wreq[k] = 1'b0;
      fr = 0; fw = 0; nr = 0; nw = 0;
      rd = '0; tc = '0; td = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (rresp[k]) begin
            nr++;
            if (fr == 0) begin fr = c; rd = rdata[k]; end
         end
         if (wresp[k]) begin
            nw++;
            if (fw == 0) begin fw = c; tc = tcode[k]; td = tdone[k]; end
         end
         if (c < 8) begin @(posedge clk); #1; end
      end
   endtask

   initial begin
      int fr, fw, nr, nw, cnt;
      logic [31:0] rd, tc;
      logic td;

      repeat (3) @(posedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_rresp%0d", k), 32'(rresp[k]), 0);
         chk($sformatf("rst_rdata%0d", k), rdata[k], 0);
         chk($sformatf("rst_done%0d", k), 32'(tdone[k]), 0);
         chk($sformatf("rst_code%0d", k), tcode[k], 0);
         chk($sformatf("rst_berr%0d", k), 32'(berr[k]), 0);
      end
      rst_n = 1'b1;

      // Back-to-back write then read at latency 1.
      @(posedge clk); #1;
      addr = 32'h10; wdata = 32'hDEAD_BEEF; strb = 4'hF; wreq[0] = 1'b1;
      @(posedge clk); #1;
      chk("b2b_wresp", 32'(wresp[0]), 1);
      chk("b2b_no_rresp", 32'(rresp[0]), 0);
      wreq[0] = 1'b0; rreq[0] = 1'b1;
      @(posedge clk); #1;
      rreq[0] = 1'b0;
      chk("b2b_rresp", 32'(rresp[0]), 1);
      chk("b2b_wresp_gone", 32'(wresp[0]), 0);
      chk("b2b_rdata", rdata[0], 32'hDEAD_BEEF);
      @(posedge clk); #1;
      chk("idle_rdata", rdata[0], 0);
      chk("idle_rresp", 32'(rresp[0]), 0);

      // Read latency 4.
      xact(1, 1, 0, 32'h20, 32'h1234_5678, 4'hF, fr, fw, nr, nw, rd, tc, td);
      chk("pre_wlat", fw, 1);
      xact(1, 0, 1, 32'h20, 0, 4'h0, fr, fw, nr, nw, rd, tc, td);
      chk("lat4_first", fr, 4);
      chk("lat4_count", nr, 1);
      chk("lat4_data", rd, 32'h1234_5678);
      chk("lat4_no_berr", 32'(berr[1]), 0);

      // Byte strobes and the empty strobe.
      xact(0, 1, 0, 32'h30, 32'h1122_3344, 4'hF, fr, fw, nr, nw, rd, tc, td);
      xact(0, 1, 0, 32'h30, 32'hAABB_CCDD, 4'b0101, fr, fw, nr, nw, rd, tc, td);
      chk("strb_wresp_count", nw, 1);
      xact(0, 0, 1, 32'h30, 0, 4'h0, fr, fw, nr, nw, rd, tc, td);
      chk("strb_data", rd, 32'h11BB_33DD);
      xact(0, 1, 0, 32'h30, 32'hFFFF_FFFF, 4'h0, fr, fw, nr, nw, rd, tc, td);
      chk("strb0_wresp", fw, 1);
      xact(0, 0, 1, 32'h30, 0, 4'h0, fr, fw, nr, nw, rd, tc, td);
      chk("strb0_data", rd, 32'h11BB_33DD);

      // Out of range, then in-range still works.
      chk("oor_berr_before", 32'(berr[0]), 0);
      xact(0, 0, 1, 32'h2000, 0, 4'h0, fr, fw, nr, nw, rd, tc, td);
      chk("oor_rlat", fr, 1);
      chk("oor_rdata", rd, 0);
      chk("oor_berr", 32'(berr[0]), 1);
      xact(0, 0, 1, 32'h10, 0, 4'h0, fr, fw, nr, nw, rd, tc, td);
      chk("after_oor_data", rd, 32'hDEAD_BEEF);
      chk("berr_sticky", 32'(berr[0]), 1);

      // Top word of the window on the latency-3 memory.
      xact(2, 1, 0, 32'h1FFC, 32'hCAFE_F00D, 4'hF, fr, fw, nr, nw, rd, tc, td);
      xact(2, 0, 1, 32'h1FFC, 0, 4'h0, fr, fw, nr, nw, rd, tc, td);
      chk("top_lat3", fr, 3);
      chk("top_data", rd, 32'hCAFE_F00D);
      chk("top_berr", 32'(berr[2]), 0);

      // Simultaneous read and write: only the write completes.
      xact(1, 1, 1, 32'h40, 32'h5, 4'hF, fr, fw, nr, nw, rd, tc, td);
      chk("conf_wlat", fw, 1);
      chk("conf_nw", nw, 1);
      chk("conf_nr", nr, 0);
      chk("conf_berr", 32'(berr[1]), 1);
      xact(1, 0, 1, 32'h40, 0, 4'h0, fr, fw, nr, nw, rd, tc, td);
      chk("conf_mem", rd, 32'h5);

      // Tohost mailbox.
      chk("th_done_before", 32'(tdone[0]), 0);
      xact(0, 1, 0, 32'h1000, 32'h1, 4'hF, fr, fw, nr, nw, rd, tc, td);
      chk("th_done", 32'(td), 1);
      chk("th_code", tc, 32'h1);
      xact(0, 1, 0, 32'h1000, 32'h7, 4'hF, fr, fw, nr, nw, rd, tc, td);
      chk("th_code2", tcode[0], 32'h7);
      chk("th_done2", 32'(tdone[0]), 1);
      xact(0, 0, 1, 32'h1000, 0, 4'h0, fr, fw, nr, nw, rd, tc, td);
      chk("th_mem", rd, 32'h7);

      // Reset in the middle of a latency-3 read.
      @(posedge clk); #1;
      addr = 32'h1FFC; rreq[2] = 1'b1;
      @(posedge clk); #1;
      rreq[2] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rresp", 32'(rresp[2]), 0);
      chk("mid_rst_done", 32'(tdone[0]), 0);
      chk("mid_rst_code", tcode[0], 0);
      chk("mid_rst_berr", {29'd0, berr}, 0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      cnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (rresp[2]) cnt++;
      end
      chk("mid_rst_no_resp", cnt, 0);
      xact(2, 0, 1, 32'h1FFC, 0, 4'h0, fr, fw, nr, nw, rd, tc, td);
      chk("post_rst_lat", fr, 3);
      chk("post_rst_data", rd, 32'hCAFE_F00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
